// File: rtl/fixed_to_float_conv.sv
// Sequential signed fixed-point to IEEE-754 single-precision converter.
// The leading-one search shifts one bit per clock. The mantissa is truncated and never rounded.
module fixed_to_float_conv #(
    parameter int W    = 32,
    parameter int FRAC = 23
) (
    input  logic         CLK,
    input  logic         RST_FF,
    input  logic         Begin_FSM_FF,
    input  logic [W-1:0] FIXED,
    output logic         ACK_FF,
    output logic [31:0]  RESULT
);

    localparam int CW = $clog2(W);
    // Biased exponent for cnt == 0. Every legal parameter set maps this into 1..254.
    localparam logic signed [9:0] EXP_BASE = 10'(W - 1 - FRAC + 127);

    if (W < 24 || W > 64 || FRAC < 0 || FRAC > W - 1 || (W - 1 - FRAC) > 127 || FRAC > 126) begin : g_param_check
        $error("fixed_to_float_conv: W/FRAC outside the representable exponent range");
    end

    typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   sign;
    logic [W-1:0]           mag;
    logic [CW-1:0]          cnt;
    logic                   start;
    logic                   norm_done;
    logic signed [9:0]      exp_full;
    logic [31:0]            packed_word;

    assign start     = Begin_FSM_FF && (state == IDLE || state == DONE);
    assign norm_done = (mag == '0) || mag[W-1];

    always_ff @(posedge CLK or posedge RST_FF) begin
        if (RST_FF) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = NORM;
            NORM:    if (norm_done) next_state = PACK;
            PACK:    next_state = DONE;
            DONE:    if (start) next_state = NORM;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ACK_FF      = (state == DONE);
        exp_full    = EXP_BASE - 10'(cnt);
        packed_word = '0;
        if (mag != '0) packed_word = {sign, exp_full[7:0], mag[W-2 -: 23]};
    end

    // NOTE: sequential state uses non-blocking assignments, so every register sees pre-edge values.
    always_ff @(posedge CLK or posedge RST_FF) begin
        if (RST_FF) begin
            sign   <= 1'b0;
            mag    <= '0;
            cnt    <= '0;
            RESULT <= '0;
        end else if (start) begin
            sign <= FIXED[W-1];
            // The two's-complement negation of the most negative input gives 2^(W-1), which fits unsigned.
            mag  <= FIXED[W-1] ? (~FIXED) + W'(1) : FIXED;
            cnt  <= '0;
        end else if (state == NORM && !norm_done) begin
            mag <= mag << 1;
            cnt <= cnt + CW'(1);
        end else if (state == PACK) begin
            RESULT <= packed_word;
        end
    end

endmodule
